// File: rtl/ro_capture_ctrl.sv
// Sequencer and trace buffer for the ring-oscillator sampler: arms, waits for a
// trigger, captures DEPTH adder-tree results and drains them on a valid/ready stream.
module ro_capture_ctrl #(
   parameter  int unsigned N                = 8,
   parameter  int unsigned WIDTH            = 16,
   parameter  int unsigned NUM_SAMPLE_WIDTH = 3,
   parameter  int unsigned DEPTH            = 64,
   parameter  int unsigned TIMEOUT_WIDTH    = 16,
   localparam int unsigned RW               = WIDTH + $clog2(N)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        arm,
   input  logic [NUM_SAMPLE_WIDTH-1:0] cfg_num_samples,
   input  logic                        trig,
   input  logic                        abort,
   output logic                        ro_go,
   output logic [NUM_SAMPLE_WIDTH-1:0] ro_num_samples,
   input  logic [RW-1:0]               ro_result,
   input  logic                        ro_valid,
   output logic [RW-1:0]               rd_data,
   output logic                        rd_valid,
   input  logic                        rd_ready,
   output logic                        rd_last,
   output logic                        busy,
   output logic                        err_timeout
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] LAST_WR = CW'(DEPTH - 1);
   // Watchdog fires on the cycle its count reaches the all-ones value.
   localparam logic [TIMEOUT_WIDTH-1:0] WDOG_FIRE = TIMEOUT_WIDTH'((64'd1 << TIMEOUT_WIDTH) - 64'd2);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

   state_t                   state;
   logic [CW-1:0]            wptr;
   logic [CW-1:0]            rptr;
   logic [CW-1:0]            count;
   logic [TIMEOUT_WIDTH-1:0] wdog;
   logic [RW-1:0]            mem [DEPTH];

   logic wr_en;
   logic xfer;
   logic load;

   assign wr_en = (state == CAPTURE) && ro_valid;
   assign xfer  = rd_valid && rd_ready;
   assign load  = !rd_valid || xfer;

   // Trace storage: no reset, contents are only meaningful below wptr.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[AW-1:0]] <= ro_result;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         wptr           <= '0;
         rptr           <= '0;
         count          <= '0;
         wdog           <= '0;
         ro_go          <= 1'b0;
         ro_num_samples <= '0;
         rd_data        <= '0;
         rd_valid       <= 1'b0;
         rd_last        <= 1'b0;
         busy           <= 1'b0;
         err_timeout    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arm && !abort) begin
                  ro_num_samples <= cfg_num_samples;
                  err_timeout    <= 1'b0;
                  busy           <= 1'b1;
                  state          <= ARMED;
               end
            end
            ARMED: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (trig) begin
                  ro_go <= 1'b1;
                  wdog  <= '0;
                  wptr  <= '0;
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (abort) begin
                  ro_go <= 1'b0;
                  wptr  <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (ro_valid) begin
                  wdog <= '0;
                  wptr <= wptr + CW'(1);
                  if (wptr == LAST_WR) begin
                     ro_go <= 1'b0;
                     count <= DEPTH_C;
                     rptr  <= '0;
                     state <= DRAIN;
                  end
               end else if (wdog == WDOG_FIRE) begin
                  // Results stopped arriving: keep whatever was captured.
                  wdog        <= wdog + TIMEOUT_WIDTH'(1);
                  err_timeout <= 1'b1;
                  ro_go       <= 1'b0;
                  rptr        <= '0;
                  if (wptr == '0) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     count <= wptr;
                     state <= DRAIN;
                  end
               end else begin
                  wdog <= wdog + TIMEOUT_WIDTH'(1);
               end
            end
            DRAIN: begin
               if (abort || (xfer && rd_last)) begin
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
                  wptr     <= '0;
                  rptr     <= '0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else if (load) begin
                  // Refill the output register whenever it is empty or being taken.
                  rd_data  <= mem[rptr[AW-1:0]];
                  rd_valid <= 1'b1;
                  rd_last  <= (rptr == count - CW'(1));
                  rptr     <= rptr + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ro_capture_ctrl.sv
// Randomized scoreboard bench for ro_capture_ctrl: stimulus pushes the expected
// trace, an independent monitor pops and compares on every stream transfer.
module tb_ro_capture_ctrl;

   localparam int unsigned RW    = 19;
   localparam int unsigned DEPTH = 64;

   typedef struct {
      logic [RW-1:0] d;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          arm = 1'b0;
   logic [2:0]    cfg_num_samples = '0;
   logic          trig = 1'b0;
   logic          abort = 1'b0;
   logic          ro_go;
   logic [2:0]    ro_num_samples;
   logic [RW-1:0] ro_result = '0;
   logic          ro_valid = 1'b0;
   logic [RW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_ready = 1'b1;
   logic          rd_last;
   logic          busy;
   logic          err_timeout;

   int   total = 0;
   int   bad = 0;
   bit   rdy_rand = 1'b0;
   exp_t exp_q[$];

   logic          held = 1'b0;
   logic [RW-1:0] held_d = '0;
   logic          held_l = 1'b0;

   ro_capture_ctrl #(
      .N(8), .WIDTH(16), .NUM_SAMPLE_WIDTH(3), .DEPTH(DEPTH), .TIMEOUT_WIDTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .cfg_num_samples(cfg_num_samples),
      .trig(trig), .abort(abort), .ro_go(ro_go), .ro_num_samples(ro_num_samples),
      .ro_result(ro_result), .ro_valid(ro_valid), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
      .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Consumer: ready either held high or a fair coin each cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         rd_ready = rdy_rand ? 1'($urandom) : 1'b1;
      end
   end

   // Monitor: samples the stream mid-cycle, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && rd_valid) begin
            if (held) begin
               chk("stall_data", 32'(rd_data), 32'(held_d));
               chk("stall_last", 32'(rd_last), 32'(held_l));
            end
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 32'(rd_valid), 32'(0));
               held = 1'b0;
            end else if (rd_ready) begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rd_data", 32'(rd_data), 32'(e.d));
               chk("rd_last", 32'(rd_last), 32'(e.last));
               held = 1'b0;
            end else begin
               held   = 1'b1;
               held_d = rd_data;
               held_l = rd_last;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   task automatic arm_trig(input logic [2:0] c);
      arm = 1'b1;
      cfg_num_samples = c;
      tick();
      arm = 1'b0;
      chk("armed_nsamp", 32'(ro_num_samples), 32'(c));
      chk("armed_busy", 32'(busy), 32'(1));
      chk("armed_go", 32'(ro_go), 32'(0));
      trig = 1'b1;
      tick();
      trig = 1'b0;
      chk("go_start", 32'(ro_go), 32'(1));
   endtask

   // Behaves as ro_top: n results with random idle gaps; optionally aborts on one.
   task automatic capture(input int n, input int gmin, input int gmax, input bit use_idx,
                          input bit keep, input int abort_at, input int last_idx);
      for (int i = 0; i < n; i++) begin
         int unsigned gap;
         logic [RW-1:0] data;
         gap = $urandom_range(gmax, gmin);
         repeat (gap) begin
            tick();
            chk("go_hold", 32'(ro_go), 32'(1));
         end
         data = use_idx ? RW'(i) : RW'($urandom);
         ro_valid  = 1'b1;
         ro_result = data;
         if (i == abort_at) abort = 1'b1;
         else if (keep) exp_q.push_back('{d: data, last: (i == last_idx)});
         tick();
         ro_valid = 1'b0;
         abort    = 1'b0;
         if (i == abort_at) begin
            chk("abort_go", 32'(ro_go), 32'(0));
            chk("abort_busy", 32'(busy), 32'(0));
            return;
         end
         if (i == DEPTH - 1) begin
            chk("go_off", 32'(ro_go), 32'(0));
            chk("drain_busy", 32'(busy), 32'(1));
         end else if (i < n - 1) begin
            chk("go_hold", 32'(ro_go), 32'(1));
         end
      end
   endtask

   task automatic wait_drain(output int k);
      k = 0;
      while (k < 2000 && !(exp_q.size() == 0 && !rd_valid)) begin
         tick();
         k++;
      end
      chk("drain_done", 32'(exp_q.size() == 0 && !rd_valid), 32'(1));
      chk("idle_busy", 32'(busy), 32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int k;
      logic [2:0] c;

      // Reset values while held in reset
      #12;
      chk("rst_go", 32'(ro_go), 32'(0));
      chk("rst_nsamp", 32'(ro_num_samples), 32'(0));
      chk("rst_valid", 32'(rd_valid), 32'(0));
      chk("rst_data", 32'(rd_data), 32'(0));
      chk("rst_last", 32'(rd_last), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_err", 32'(err_timeout), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1: normal capture, result = index every third cycle, ready always high
      arm_trig(3'b111);
      capture(DEPTH, 2, 2, 1'b1, 1'b1, -1, DEPTH - 1);
      wait_drain(k);
      chk("drain_rate", 32'(k <= DEPTH + 2), 32'(1));

      // 2: random data, random gaps, 50% backpressure
      rdy_rand = 1'b1;
      arm_trig(3'd2);
      capture(DEPTH, 0, 3, 1'b0, 1'b1, -1, DEPTH - 1);
      wait_drain(k);
      rdy_rand = 1'b0;

      // 3: watchdog after 10 results
      arm_trig(3'd4);
      capture(10, 0, 3, 1'b1, 1'b1, -1, 9);
      k = 0;
      while (!err_timeout && k < 40) begin
         tick();
         k++;
      end
      chk("wdog_cycles", 32'(k), 32'(15));
      chk("wdog_err", 32'(err_timeout), 32'(1));
      chk("wdog_go", 32'(ro_go), 32'(0));
      wait_drain(k);
      chk("err_sticky", 32'(err_timeout), 32'(1));
      arm = 1'b1;
      cfg_num_samples = 3'd1;
      tick();
      arm = 1'b0;
      chk("err_cleared", 32'(err_timeout), 32'(0));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("armed_abort_busy", 32'(busy), 32'(0));
      chk("abort_keeps_nsamp", 32'(ro_num_samples), 32'(1));

      // 4: abort on the 20th write, then abort+trig together in ARMED
      arm_trig(3'd6);
      capture(DEPTH, 0, 2, 1'b0, 1'b0, 19, -1);
      repeat (8) tick();
      chk("abort_no_valid", 32'(rd_valid), 32'(0));
      chk("abort_nsamp", 32'(ro_num_samples), 32'(6));
      arm = 1'b1;
      cfg_num_samples = 3'd3;
      tick();
      arm = 1'b0;
      trig  = 1'b1;
      abort = 1'b1;
      tick();
      trig  = 1'b0;
      abort = 1'b0;
      chk("abort_trig_busy", 32'(busy), 32'(0));
      chk("abort_trig_go", 32'(ro_go), 32'(0));
      tick();
      chk("abort_trig_go2", 32'(ro_go), 32'(0));

      // 6: ignored controls
      trig = 1'b1;
      tick();
      trig = 1'b0;
      chk("idle_trig_busy", 32'(busy), 32'(0));
      chk("idle_trig_go", 32'(ro_go), 32'(0));
      c = 3'($urandom_range(7, 1));
      arm = 1'b1;
      cfg_num_samples = c;
      tick();
      arm = 1'b0;
      ro_valid  = 1'b1;
      ro_result = RW'($urandom);
      tick();
      ro_valid = 1'b0;
      chk("armed_valid_busy", 32'(busy), 32'(1));
      chk("armed_valid_go", 32'(ro_go), 32'(0));
      trig = 1'b1;
      tick();
      trig = 1'b0;
      chk("ign_go_start", 32'(ro_go), 32'(1));
      arm = 1'b1;
      cfg_num_samples = ~c;
      tick();
      arm = 1'b0;
      chk("cap_arm_nsamp", 32'(ro_num_samples), 32'(c));
      chk("cap_arm_go", 32'(ro_go), 32'(1));
      capture(DEPTH, 0, 3, 1'b0, 1'b1, -1, DEPTH - 1);
      wait_drain(k);

      // 5: asynchronous reset in the middle of a drain
      rdy_rand = 1'b1;
      arm_trig(3'd5);
      capture(DEPTH, 0, 0, 1'b0, 1'b1, -1, DEPTH - 1);
      k = 0;
      while (exp_q.size() > 40 && k < 500) begin
         tick();
         k++;
      end
      chk("pre_reset_busy", 32'(busy), 32'(1));
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("async_go", 32'(ro_go), 32'(0));
      chk("async_nsamp", 32'(ro_num_samples), 32'(0));
      chk("async_valid", 32'(rd_valid), 32'(0));
      chk("async_data", 32'(rd_data), 32'(0));
      chk("async_last", 32'(rd_last), 32'(0));
      chk("async_busy", 32'(busy), 32'(0));
      chk("async_err", 32'(err_timeout), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      arm_trig(3'($urandom));
      capture(DEPTH, 0, 3, 1'b0, 1'b1, -1, DEPTH - 1);
      wait_drain(k);
      rdy_rand = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ro_capture_ctrl.md
Name: ro_capture_ctrl

Overview:
Sequencer and trace buffer for the ring-oscillator sampler (ro_top). It latches the sample configuration when armed and waits for an external trigger. It then drives go, captures DEPTH consecutive adder-tree results into an internal buffer, and drains them on a valid/ready stream toward the host/UART side. It sits between ro_top and the readout logic and owns all control of the sampler.

Parameters:
N, 8, number of ring oscillators in ro_top; sets the result width.
WIDTH, 16, per-oscillator counter width in ro_top.
NUM_SAMPLE_WIDTH, 3, width of the num_samples configuration field.
DEPTH, 64, number of results captured per trigger; power of two, at least 2.
TIMEOUT_WIDTH, 16, width of the no-result watchdog counter.
RW (derived, not overridable), WIDTH+$clog2(N), result width (19 by default).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
arm  in  1  single-cycle request to arm; honoured only in IDLE
cfg_num_samples  in  NUM_SAMPLE_WIDTH  sample setting; latched on an accepted arm
trig  in  1  capture trigger (level); sampled only in ARMED
abort  in  1  cancels any operation; returns to IDLE
ro_go  out  1  enable to ro_top
ro_num_samples  out  NUM_SAMPLE_WIDTH  latched configuration to ro_top
ro_result  in  RW  add_tree_result from ro_top
ro_valid  in  1  add_tree_valid_out from ro_top
rd_data  out  RW  drained sample
rd_valid  out  1  rd_data is valid
rd_ready  in  1  consumer accepts the word
rd_last  out  1  marks the final word of the trace
busy  out  1  high in every state other than IDLE
err_timeout  out  1  sticky watchdog flag; cleared on the next accepted arm

Behaviour:
- Reset (asynchronous, takes effect with no clock edge):
  - Outputs: ro_go=0, ro_num_samples=0, rd_valid=0, rd_data=0, rd_last=0, busy=0, err_timeout=0.
  - Internal: state=IDLE, write and read pointers=0, watchdog=0.
  - Buffer contents are don't-care.
- All outputs are registered.
- IDLE:
  - arm=1 latches cfg_num_samples into ro_num_samples, clears err_timeout, and moves to ARMED.
  - abort=1 in the same cycle wins: stay IDLE, nothing is latched.
- ARMED:
  - abort=1 moves to IDLE.
  - Otherwise trig=1 moves to CAPTURE, with ro_go=1 from the next edge.
  - abort outranks trig when both are high.
  - trig outside ARMED is ignored; arm outside IDLE is ignored.
- CAPTURE:
  - ro_go is held at 1.
  - Each cycle with ro_valid=1 writes ro_result to buf[wptr] and increments wptr.
  - ro_valid in any other state is ignored.
  - On the write of entry DEPTH-1: ro_go=0 next cycle, state moves to DRAIN with count=DEPTH.
- Watchdog (CAPTURE only):
  - Clears on every ro_valid=1 cycle and on entry to CAPTURE; increments otherwise.
  - When it reaches 2^TIMEOUT_WIDTH-1: set err_timeout=1 and ro_go=0.
  - Then go to DRAIN with count=wptr, or to IDLE if wptr=0.
- abort in CAPTURE: ro_go=0 next cycle, captured data discarded, state moves to IDLE.
- DRAIN:
  - rd_valid asserts within 2 cycles of entry.
  - Words are presented in capture order, buf[0] first.
  - A transfer occurs when rd_valid && rd_ready.
  - While rd_valid && !rd_ready, rd_data and rd_last hold stable.
  - Sustains 1 word/cycle when rd_ready is held at 1.
  - rd_last=1 only with word count-1.
  - After the last transfer: rd_valid=0, pointers cleared, state moves to IDLE.
  - abort in DRAIN: rd_valid=0 next cycle, state moves to IDLE.
- ro_num_samples holds its latched value until the next accepted arm; abort does not clear it.
- Pointer and count registers are $clog2(DEPTH)+1 bits; no wrap-around is possible within one trace.

Test Plan:
1. Normal capture: ro_top model gives ro_valid every 3 cycles with result = index; arm with cfg=3'b111, then trig. Required: ro_num_samples=7; ro_go high from trig+1 until the 64th write; rd_data 0..63 in order; rd_last only on 63; busy low after the final transfer.
2. Backpressure: rd_ready pseudo-random at 50%. Required: rd_data stable during stalls; exactly 64 words, with no drop or duplicate.
3. Watchdog: TIMEOUT_WIDTH=4, ro_valid stops after 10 results. Required: err_timeout=1 15 cycles after the last valid, ro_go low, 10 words drained with rd_last on the 10th. A subsequent arm clears err_timeout.
4. Abort: abort at the 20th write in CAPTURE. Required: ro_go=0 next cycle, rd_valid never asserts, busy=0. Also abort+trig in the same cycle in ARMED, which must return to IDLE.
5. Async reset: drop rst_n mid-DRAIN between clock edges. Required: all outputs go to reset values immediately. A subsequent arm/trig trace completes correctly.
6. Ignored controls: trig in IDLE, arm in CAPTURE, ro_valid in ARMED. Required: no state change, no write, and ro_num_samples unchanged.
